// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program counter, run-time loadable jump-target LUT and
// hardware call/return stack, plus the req/done run handshake.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   req          start request, sampled in IDLE and FAULT
//   stall        hold PC this cycle; jump inputs ignored
//   jmp_valid    current instruction is a jump/branch
//   jmp_take     branch condition; jump applies only when valid & take
//   jmp_mode     00 relative, 01 absolute, 10 call, 11 return
//   lut_idx      LUT entry selected for the jump (combinational read)
//   lut_wr_en    LUT write strobe (commits at the edge)
//   lut_wr_idx   LUT write index
//   lut_wr_data  LUT write data
//   prog_ctr     current fetch address (registered)
//   fetch_en     prog_ctr is a valid fetch this cycle (combinational)
//   busy         state is RUN (decoded)
//   done         one-cycle end-of-run pulse (decoded)
//   fault        sticky stack overflow/underflow flag (registered)
//   depth        current call-stack occupancy (registered)
module fetch_sequencer #(
    parameter int unsigned D        = 12,
    parameter int unsigned LW       = 5,
    parameter int unsigned SD       = 4,
    parameter int unsigned END_ADDR = 128
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req,
    input  logic                     stall,
    input  logic                     jmp_valid,
    input  logic                     jmp_take,
    input  logic [1:0]               jmp_mode,
    input  logic [LW-1:0]            lut_idx,
    input  logic                     lut_wr_en,
    input  logic [LW-1:0]            lut_wr_idx,
    input  logic [D-1:0]             lut_wr_data,
    output logic [D-1:0]             prog_ctr,
    output logic                     fetch_en,
    output logic                     busy,
    output logic                     done,
    output logic                     fault,
    output logic [$clog2(SD+1)-1:0]  depth
);

    localparam int unsigned DW = $clog2(SD + 1);
    localparam int unsigned SW = (SD > 1) ? $clog2(SD) : 1;
    localparam int unsigned LD = 1 << LW;

    localparam logic [1:0] MODE_REL  = 2'b00;
    localparam logic [1:0] MODE_ABS  = 2'b01;
    localparam logic [1:0] MODE_CALL = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DONE  = 2'b10,
        ST_FAULT = 2'b11
    } state_t;

    state_t          state_q, state_n;
    logic [D-1:0]    pc_q, pc_n;
    logic [DW-1:0]   depth_q, depth_n;
    logic            fault_q, fault_n;
    logic            push_c;

    logic [D-1:0]    lut_q   [LD];
    logic [D-1:0]    stack_q [SD];

    logic [D-1:0]    lut_rd_c;
    logic [D-1:0]    pc_inc_c;
    logic [D-1:0]    stack_top_c;
    logic            at_end_c;
    logic            take_c;

    // Datapath helpers; the LUT read sees the pre-write value in a collision cycle.
    assign lut_rd_c    = lut_q[lut_idx];
    assign pc_inc_c    = pc_q + D'(1);
    assign stack_top_c = (depth_q == '0) ? '0 : stack_q[SW'(depth_q - DW'(1))];
    assign at_end_c    = (pc_q == D'(END_ADDR));
    assign take_c      = jmp_valid & jmp_take;

    // Next-state, PC and stack control.
    always_comb begin
        state_n = state_q;
        pc_n    = pc_q;
        depth_n = depth_q;
        fault_n = fault_q;
        push_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                pc_n = '0;
                if (req) begin
                    state_n = ST_RUN;
                    depth_n = '0;
                end
            end
            ST_RUN: begin
                if (at_end_c) begin
                    state_n = ST_DONE;
                end else if (!stall) begin
                    pc_n = pc_inc_c;
                    if (take_c) begin
                        case (jmp_mode)
                            MODE_REL: pc_n = pc_q + lut_rd_c;
                            MODE_ABS: pc_n = lut_rd_c;
                            MODE_CALL: begin
                                if (depth_q < DW'(SD)) begin
                                    push_c  = 1'b1;
                                    depth_n = depth_q + DW'(1);
                                    pc_n    = lut_rd_c;
                                end else begin
                                    pc_n    = pc_q;
                                    state_n = ST_FAULT;
                                    fault_n = 1'b1;
                                end
                            end
                            default: begin
                                if (depth_q != '0) begin
                                    pc_n    = stack_top_c;
                                    depth_n = depth_q - DW'(1);
                                end else begin
                                    pc_n    = pc_q;
                                    state_n = ST_FAULT;
                                    fault_n = 1'b1;
                                end
                            end
                        endcase
                    end
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
                pc_n    = '0;
            end
            ST_FAULT: begin
                if (req) begin
                    state_n = ST_RUN;
                    pc_n    = '0;
                    depth_n = '0;
                    fault_n = 1'b0;
                end
            end
            default: begin
                state_n = ST_IDLE;
                pc_n    = '0;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            depth_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_n;
            pc_q    <= pc_n;
            depth_q <= depth_n;
            fault_q <= fault_n;
        end
    end

    // Jump-target LUT, writable in every state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LD; i++) begin
                lut_q[LW'(i)] <= '0;
            end
        end else if (lut_wr_en) begin
            lut_q[lut_wr_idx] <= lut_wr_data;
        end
    end

    // Call stack storage; occupancy lives in depth_q.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SD; i++) begin
                stack_q[SW'(i)] <= '0;
            end
        end else if (push_c) begin
            stack_q[SW'(depth_q)] <= pc_inc_c;
        end
    end

    assign prog_ctr = pc_q;
    assign fetch_en = (state_q == ST_RUN) & ~stall & ~at_end_c;
    assign busy     = (state_q == ST_RUN);
    assign done     = (state_q == ST_DONE);
    assign fault    = fault_q;
    assign depth    = depth_q;

endmodule
